period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//  Parametrised successor to the single-channel cycle counter. Measures iSignal either as full
//  period (rise->rise) or high-pulse width (rise->fall), counted in iCE ticks. Adds input
//  synchroniser, edge detection, timeout/saturation flag and a one-cycle result-valid strobe.
//  Sits between the prescaler (iCE source) and the display/UART reporting logic.
// PARAMETERS
//  WIDTH        14     width of count and oCycles
//  SAT_VALUE    10000  saturation/timeout tick count; must be < 2**WIDTH (elaboration error otherwise)
//  SYNC_STAGES  2      flip-flops in the iSignal synchroniser, >= 2
// PORTS
//  iClk       in   1      single clock, all logic rising-edge
//  iRst_n     in   1      asynchronous active-low reset
//  iCE        in   1      tick enable; count advances only on cycles with iCE=1
//  iSignal    in   1      asynchronous measured signal
//  iMode      in   1      0 = period (rise->rise), 1 = high width (rise->fall)
//  oCycles    out  WIDTH  last completed measurement, held until next oValid
//  oValid     out  1      one-cycle strobe: oCycles/oOverflow updated this cycle
//  oOverflow  out  1      last measurement hit SAT_VALUE (timeout); updated with oValid
//  oBusy      out  1      1 while in COUNT state
// BEHAVIOUR
//  - Reset (async, iRst_n=0): oCycles=0, oValid=0, oOverflow=0, oBusy=0, state=ARM, count=0,
//    synchroniser and edge-history flops=0. Deassertion mid-measurement discards all progress.
//  - Sync: sSig = iSignal after SYNC_STAGES flops. Edge pulses rise/fall asserted in the cycle
//    where sSig differs from its 1-cycle delayed copy. Input change -> edge pulse = SYNC_STAGES+1 clocks.
//  - FSM states (2): ARM, COUNT.
//    ARM: count=0. On rise -> COUNT. All other events ignored.
//    COUNT: count += iCE each cycle (start-edge cycle not counted).
//      Terminating edge (rise if iMode=0, fall if iMode=1): next = count + iCE (saturated);
//      oCycles<=next, oOverflow<=0, oValid=1 next cycle.
//      iMode=0 -> stay COUNT, count<=0 (the terminating rise is the next start).
//      iMode=1 -> ARM.
//      Saturation: if count+iCE reaches SAT_VALUE with no terminating edge -> oCycles<=SAT_VALUE,
//      oOverflow<=1, oValid=1, -> ARM. Count never exceeds SAT_VALUE; no wrap-around.
//      Saturation and terminating edge in same cycle: edge wins (oOverflow=0, oCycles=SAT_VALUE).
//  - oValid registered: high exactly one cycle after the terminating/timeout cycle; never
//    two consecutive cycles unless edges arrive on consecutive cycles (period mode).
//  - iMode sampled every cycle; a change while in COUNT aborts: -> ARM, count=0, no oValid,
//    oCycles/oOverflow keep previous values. A change in ARM has no effect.
//  - fall in iMode=0, or rise while COUNT in iMode=1 (impossible after sync), are ignored.
//  - Arithmetic unsigned, WIDTH bits; saturating compare is >= SAT_VALUE.
//  - oBusy = (state==COUNT), combinational from the state register.
// STRUCTURE
//  - period_meter_pkg: state encoding (ST_ARM, ST_COUNT), mode constants
//    (MODE_PERIOD=1'b0, MODE_HIGH=1'b1).
//  - Sub-module sync_edge_detect #(SYNC_STAGES): iClk, iRst_n, iAsync -> oLevel, oRise, oFall.
//    Reused by other asynchronous-input blocks.
//  - Top: FSM + saturating counter + output registers, one sequential and one combinational process.
// TESTING
//  1 Period mode, iCE=1 always, square wave 25 clk high/25 low -> first oValid after 2nd rise,
//    oCycles=50, oOverflow=0; repeats every 50 clocks with oCycles=50.
//  2 High mode, iCE every 4th clock, pulse high 40 clocks -> oCycles=10, single oValid, then ARM
//    (oBusy=0) until next rise.
//  3 Timeout: SAT_VALUE=100, one rise then signal held high (period mode), iCE=1 -> oValid with
//    oCycles=100, oOverflow=1, oBusy falls; next rise restarts and next result has oOverflow=0.
//  4 Mode abort: period mode, rise, 30 clocks, toggle iMode -> no oValid, state ARM,
//    oCycles keeps prior value.
//  5 Reset mid-count: assert iRst_n=0 asynchronously between clock edges during COUNT -> all
//    outputs 0 immediately; after release first result needs a fresh start edge.
//  6 Latency/glitch: single-clock input pulse -> edge seen SYNC_STAGES+1 clocks later; iCE=0
//    throughout a 20-clock period -> oCycles=0, oValid still asserted.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared encodings for the period/high-width meter.
package period_meter_pkg;

   typedef enum logic {
      ST_ARM   = 1'b0,
      ST_COUNT = 1'b1
   } stateT;

   localparam logic MODE_PERIOD = 1'b0;
   localparam logic MODE_HIGH   = 1'b1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser for an asynchronous input, followed by
// single-cycle rise/fall pulses on the synchronised level.
module sync_edge_detect #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iAsync,
   output logic oLevel,
   output logic oRise,
   output logic oFall
);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   levelQ;

   // Shift the async input through the synchroniser and keep a one-cycle history
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         syncQ  <= '0;
         levelQ <= 1'b0;
      end else begin
         syncQ  <= {syncQ[SYNC_STAGES-2:0], iAsync};
         levelQ <= syncQ[SYNC_STAGES-1];
      end
   end

   assign oLevel = syncQ[SYNC_STAGES-1];
   assign oRise  = oLevel & ~levelQ;
   assign oFall  = ~oLevel & levelQ;

endmodule

// File: rtl/period_meter.sv
// Measures iSignal period (rise->rise) or high width (rise->fall) in iCE
// ticks, with timeout/saturation and a one-cycle result strobe.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned WIDTH       = 14,
   parameter int unsigned SAT_VALUE   = 10000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iCE,
   input  logic             iSignal,
   input  logic             iMode,
   output logic [WIDTH-1:0] oCycles,
   output logic             oValid,
   output logic             oOverflow,
   output logic             oBusy
);

   if (longint'(SAT_VALUE) >= (longint'(1) << WIDTH)) begin : gBadSat
      $error("period_meter: SAT_VALUE must be below 2**WIDTH");
   end
   if (SYNC_STAGES < 2) begin : gBadSync
      $error("period_meter: SYNC_STAGES must be at least 2");
   end

   localparam logic [WIDTH-1:0] SAT_W   = WIDTH'(SAT_VALUE);
   localparam logic [WIDTH:0]   SAT_EXT = (WIDTH+1)'(SAT_VALUE);

   logic             sLevel, sRise, sFall;
   stateT            stateQ, stateD;
   logic [WIDTH-1:0] countQ, countD;
   logic [WIDTH-1:0] cyclesQ, cyclesD;
   logic             ovfQ, ovfD;
   logic             validQ, validD;
   logic             modeQ;
   logic [WIDTH:0]   sum;
   logic             atSat;
   logic [WIDTH-1:0] nextCount;
   logic             termEdge;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) uSync (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .iAsync(iSignal),
      .oLevel(sLevel),
      .oRise (sRise),
      .oFall (sFall)
   );

   // State, counter, result and mode-history registers
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateQ  <= ST_ARM;
         countQ  <= '0;
         cyclesQ <= '0;
         ovfQ    <= 1'b0;
         validQ  <= 1'b0;
         modeQ   <= MODE_PERIOD;
      end else begin
         stateQ  <= stateD;
         countQ  <= countD;
         cyclesQ <= cyclesD;
         ovfQ    <= ovfD;
         validQ  <= validD;
         modeQ   <= iMode;
      end
   end

   // Next-state, saturating count and result update
   always_comb begin
      stateD    = stateQ;
      countD    = countQ;
      cyclesD   = cyclesQ;
      ovfD      = ovfQ;
      validD    = 1'b0;
      // One spare bit so count+1 cannot wrap when SAT_VALUE is 2**WIDTH-1
      sum       = {1'b0, countQ} + (WIDTH+1)'(iCE);
      atSat     = (sum >= SAT_EXT);
      nextCount = atSat ? SAT_W : sum[WIDTH-1:0];
      termEdge  = (iMode == MODE_HIGH) ? (sFall & ~sLevel) : sRise;
      unique case (stateQ)
         ST_ARM: begin
            countD = '0;
            if (sRise) stateD = ST_COUNT;
         end
         ST_COUNT: begin
            if (iMode != modeQ) begin
               stateD = ST_ARM;
               countD = '0;
            end else if (termEdge) begin
               cyclesD = nextCount;
               ovfD    = 1'b0;
               validD  = 1'b1;
               countD  = '0;
               if (iMode == MODE_HIGH) stateD = ST_ARM;
            end else if (atSat) begin
               cyclesD = SAT_W;
               ovfD    = 1'b1;
               validD  = 1'b1;
               countD  = '0;
               stateD  = ST_ARM;
            end else begin
               countD = sum[WIDTH-1:0];
            end
         end
      endcase
   end

   assign oCycles   = cyclesQ;
   assign oValid    = validQ;
   assign oOverflow = ovfQ;
   assign oBusy     = (stateQ == ST_COUNT);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (SAT_VALUE reduced to 100 for timeout).
module tb_period_meter;

   logic        iClk = 1'b0;
   logic        iRst_n = 1'b0;
   logic        iCE = 1'b1;
   logic        iSignal = 1'b0;
   logic        iMode = 1'b0;
   logic [13:0] oCycles;
   logic        oValid, oOverflow, oBusy;

   int          checks = 0;
   int          errors = 0;
   int          validCnt = 0;
   int          lastCycles = 0;
   int          lastOvf = 0;
   int          capCycles[$];
   int          ceMode = 0;
   int          ceCnt = 0;
   int          base;

   period_meter #(
      .WIDTH      (14),
      .SAT_VALUE  (100),
      .SYNC_STAGES(2)
   ) dut (
      .iClk     (iClk),
      .iRst_n   (iRst_n),
      .iCE      (iCE),
      .iSignal  (iSignal),
      .iMode    (iMode),
      .oCycles  (oCycles),
      .oValid   (oValid),
      .oOverflow(oOverflow),
      .oBusy    (oBusy)
   );

   always #5 iClk = ~iClk;

   // Capture every result strobe shortly after the edge that produced it
   always @(posedge iClk) begin
      #1;
      if (oValid) begin
         validCnt++;
         lastCycles = int'(oCycles);
         lastOvf    = int'(oOverflow);
         capCycles.push_back(int'(oCycles));
      end
   end

   task automatic checkEq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clocks, updating iCE at each falling edge
   task automatic step(input int n);
      repeat (n) begin
         @(negedge iClk);
         ceCnt++;
         case (ceMode)
            0:       iCE = 1'b1;
            1:       iCE = (ceCnt % 4 == 0);
            default: iCE = 1'b0;
         endcase
      end
   endtask

   initial begin
      // Reset state
      step(3);
      checkEq("rst_cycles", int'(oCycles), 0);
      checkEq("rst_valid", int'(oValid), 0);
      checkEq("rst_ovf", int'(oOverflow), 0);
      checkEq("rst_busy", int'(oBusy), 0);
      iRst_n = 1'b1;
      step(3);

      // 1: period mode, 25 high / 25 low, four rises -> three results of 50
      base = validCnt;
      for (int p = 0; p < 3; p++) begin
         iSignal = 1'b1; step(25);
         iSignal = 1'b0; step(25);
      end
      iSignal = 1'b1; step(6);
      checkEq("t1_nvalid", validCnt - base, 3);
      for (int i = base; i < capCycles.size(); i++)
         checkEq("t1_cycles", capCycles[i], 50);
      checkEq("t1_ovf", lastOvf, 0);
      checkEq("t1_busy", int'(oBusy), 1);

      // 4: mode toggle mid-count aborts without a result
      base = validCnt;
      step(24);
      iMode = 1'b1; step(5);
      checkEq("t4_nvalid", validCnt - base, 0);
      checkEq("t4_busy", int'(oBusy), 0);
      checkEq("t4_cycles", int'(oCycles), 50);
      iSignal = 1'b0; step(10);
      iMode = 1'b0; step(5);
      checkEq("t4_busy_arm", int'(oBusy), 0);
      checkEq("t4_nvalid2", validCnt - base, 0);

      // 2: high mode, iCE every 4th clock, 40-clock pulse -> 10
      iMode = 1'b1; step(3);
      ceMode = 1;
      base = validCnt;
      iSignal = 1'b1; step(20);
      checkEq("t2_busy_mid", int'(oBusy), 1);
      step(20);
      iSignal = 1'b0; step(10);
      checkEq("t2_nvalid", validCnt - base, 1);
      checkEq("t2_cycles", lastCycles, 10);
      checkEq("t2_ovf", lastOvf, 0);
      checkEq("t2_busy", int'(oBusy), 0);

      // 3: timeout at 100 ticks, then a normal 60-clock period
      iMode = 1'b0; step(3);
      ceMode = 0;
      base = validCnt;
      iSignal = 1'b1; step(120);
      checkEq("t3_nvalid", validCnt - base, 1);
      checkEq("t3_cycles", lastCycles, 100);
      checkEq("t3_ovf", lastOvf, 1);
      checkEq("t3_busy", int'(oBusy), 0);
      iSignal = 1'b0; step(20);
      base = validCnt;
      iSignal = 1'b1; step(30);
      iSignal = 1'b0; step(30);
      iSignal = 1'b1; step(6);
      checkEq("t3_nvalid2", validCnt - base, 1);
      checkEq("t3_cycles2", lastCycles, 60);
      checkEq("t3_ovf2", lastOvf, 0);

      // 5: asynchronous reset between edges while counting
      step(5);
      #2 iRst_n = 1'b0;
      #1;
      checkEq("t5_cycles", int'(oCycles), 0);
      checkEq("t5_valid", int'(oValid), 0);
      checkEq("t5_ovf", int'(oOverflow), 0);
      checkEq("t5_busy", int'(oBusy), 0);
      iSignal = 1'b0;
      step(3);
      iRst_n = 1'b1;
      base = validCnt;
      step(10);
      checkEq("t5_busy_idle", int'(oBusy), 0);
      checkEq("t5_nvalid_idle", validCnt - base, 0);
      iSignal = 1'b1; step(20);
      iSignal = 1'b0; step(20);
      iSignal = 1'b1; step(6);
      checkEq("t5_nvalid", validCnt - base, 1);
      checkEq("t5_cycles2", lastCycles, 40);

      // 6: synchroniser latency with a 1-clock pulse, then iCE=0 for a 20-clock period
      iRst_n = 1'b0; iSignal = 1'b0; step(2);
      iRst_n = 1'b1; step(3);
      ceMode = 2;
      step(1);
      base = validCnt;
      iSignal = 1'b1; step(1);
      iSignal = 1'b0; step(1);
      checkEq("t6_busy_lat2", int'(oBusy), 0);
      step(1);
      checkEq("t6_busy_lat3", int'(oBusy), 1);
      step(17);
      iSignal = 1'b1; step(1);
      iSignal = 1'b0; step(5);
      checkEq("t6_nvalid", validCnt - base, 1);
      checkEq("t6_cycles", lastCycles, 0);
      checkEq("t6_ovf", lastOvf, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
